// File: rtl/la_pkg.sv
// la_pkg: shared definitions for the logic-analyzer trigger/capture block.
//   trig_edge_e     : trigger_edge encodings (immediate / rising / falling / either)
//   la_state_e      : capture FSM state encoding
//   MAX_RATE_CFG    : largest honoured rate select; larger values are clamped
//   rate_mask()     : low-bit mask of the divider count for a given rate select
package la_pkg;

   localparam int MAX_RATE_CFG = 10;
   localparam int DIV_WIDTH    = MAX_RATE_CFG;

   typedef enum logic [1:0] {
      TRIG_IMM  = 2'd0,
      TRIG_RISE = 2'd1,
      TRIG_FALL = 2'd2,
      TRIG_ANY  = 2'd3
   } trig_edge_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } la_state_e;

   function automatic logic [3:0] clamp_rate_cfg(input logic [3:0] cfg);
      return (cfg > 4'(MAX_RATE_CFG)) ? 4'(MAX_RATE_CFG) : cfg;
   endfunction

   // A tick is due whenever the masked count is zero, giving a 2^cfg period.
   function automatic logic [DIV_WIDTH-1:0] rate_mask(input logic [3:0] cfg);
      return ~({DIV_WIDTH{1'b1}} << clamp_rate_cfg(cfg));
   endfunction

endpackage

// File: rtl/la_trigger_capture_if.sv
// la_trigger_capture_if: sample write port toward the downstream FIFO.
//   sample_data      : captured probe word
//   sample_valid     : one-cycle write strobe for sample_data
//   fifo_almost_full : backpressure from the FIFO
//   master = capture block, slave = FIFO side.
interface la_trigger_capture_if #(
   parameter int INPUT_WIDTH = 6
) ();

   logic [INPUT_WIDTH-1:0] sample_data;
   logic                   sample_valid;
   logic                   fifo_almost_full;

   modport master (
      output sample_data,
      output sample_valid,
      input  fifo_almost_full
   );

   modport slave (
      input  sample_data,
      input  sample_valid,
      output fifo_almost_full
   );

endinterface

// File: rtl/la_rate_divider.sv
// la_rate_divider: sample-rate tick generator, one tick every 2^min(cfg,10)
// enabled cycles. The first enabled cycle after a clear ticks.
//   clk, rst  : clock, async active-high reset
//   en        : count enable (capture in progress)
//   clr       : synchronous clear, asserted on the trigger cycle
//   rate_cfg  : latched rate select
//   tick      : sample due this cycle
module la_rate_divider
   import la_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       clr,
   input  logic [3:0] rate_cfg,
   output logic       tick
);

   logic [DIV_WIDTH-1:0] div_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (clr) begin
         div_cnt <= '0;
      end else if (en) begin
         div_cnt <= div_cnt + DIV_WIDTH'(1);
      end
   end

   assign tick = en & ~clr & ((div_cnt & rate_mask(rate_cfg)) == '0);

endmodule

// File: rtl/la_trigger_capture.sv
// la_trigger_capture: logic-analyzer trigger and capture controller.
// Probes are synchronized, a trigger is detected on one channel, then a
// programmed number of samples is written to a downstream FIFO at a
// programmable rate.
//   clk, rst         : clock, async active-high reset
//   din              : raw probe pins (asynchronous)
//   sample_run       : level; rising edge starts, low aborts / clears
//   sample_num       : capture depth
//   sample_clk_cfg   : rate select, period 2^min(cfg,10)
//   trigger_edge     : trig_edge_e encoding
//   trigger_channel  : watched channel; out-of-range means immediate
//   wr               : sample write port (master)
//   armed            : waiting for trigger
//   capture_done     : capture complete, held until sample_run drops
//   overflow         : sticky, a due sample was dropped on backpressure
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for a sample_run rising edge
// ST_ARMED   | config latched, waiting for the trigger condition
// ST_CAPTURE | writing one sample per divider tick until the count is met
// ST_DONE    | capture complete, waiting for sample_run to drop
module la_trigger_capture
   import la_pkg::*;
#(
   parameter int INPUT_WIDTH = 6,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INPUT_WIDTH-1:0] din,
   input  logic                   sample_run,
   input  logic [CNT_WIDTH-1:0]   sample_num,
   input  logic [3:0]             sample_clk_cfg,
   input  logic [1:0]             trigger_edge,
   input  logic [2:0]             trigger_channel,
   la_trigger_capture_if.master   wr,
   output logic                   armed,
   output logic                   capture_done,
   output logic                   overflow
);

   logic [INPUT_WIDTH-1:0] sync1, sync2, hist;
   logic                   run_q;
   la_state_e              state;
   logic [CNT_WIDTH-1:0]   num_q, smp_cnt, smp_cnt_inc;
   logic [3:0]             cfg_q;
   trig_edge_e             edge_q;
   logic [2:0]             ch_q;

   logic [INPUT_WIDTH-1:0] ch_mask;
   logic ch_valid, cur_bit, prev_bit, edge_hit, trig_fire, tick, last_sample;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         hist  <= '0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   assign ch_mask  = INPUT_WIDTH'(1) << ch_q;
   assign ch_valid = int'(ch_q) < INPUT_WIDTH;
   assign cur_bit  = |(sync2 & ch_mask);
   assign prev_bit = |(hist & ch_mask);

   always_comb begin
      edge_hit = 1'b0;
      case (edge_q)
         TRIG_RISE: edge_hit = cur_bit & ~prev_bit;
         TRIG_FALL: edge_hit = ~cur_bit & prev_bit;
         TRIG_ANY:  edge_hit = cur_bit ^ prev_bit;
         default:   edge_hit = 1'b1;
      endcase
   end

   // Abort (sample_run low) takes priority over a trigger in the same cycle.
   assign trig_fire   = (state == ST_ARMED) & sample_run &
                        ((edge_q == TRIG_IMM) | ~ch_valid | edge_hit);
   assign smp_cnt_inc = smp_cnt + CNT_WIDTH'(1);
   assign last_sample = (smp_cnt_inc == num_q);

   la_rate_divider u_rate_divider (
      .clk      (clk),
      .rst      (rst),
      .en       (state == ST_CAPTURE),
      .clr      (trig_fire),
      .rate_cfg (cfg_q),
      .tick     (tick)
   );

   // run_q resets high so a sample_run level held through reset is not
   // mistaken for a start edge; a fresh 0->1 is required.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ST_IDLE;
         run_q           <= 1'b1;
         num_q           <= '0;
         smp_cnt         <= '0;
         cfg_q           <= '0;
         edge_q          <= TRIG_IMM;
         ch_q            <= '0;
         wr.sample_data  <= '0;
         wr.sample_valid <= 1'b0;
         armed           <= 1'b0;
         capture_done    <= 1'b0;
         overflow        <= 1'b0;
      end else begin
         run_q           <= sample_run;
         wr.sample_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (sample_run && !run_q) begin
                  num_q    <= sample_num;
                  cfg_q    <= sample_clk_cfg;
                  edge_q   <= trig_edge_e'(trigger_edge);
                  ch_q     <= trigger_channel;
                  smp_cnt  <= '0;
                  overflow <= 1'b0;
                  if (sample_num == '0) begin
                     state        <= ST_DONE;
                     capture_done <= 1'b1;
                  end else begin
                     state <= ST_ARMED;
                     armed <= 1'b1;
                  end
               end
            end
            ST_ARMED: begin
               if (!sample_run) begin
                  state <= ST_IDLE;
                  armed <= 1'b0;
               end else if (trig_fire) begin
                  state <= ST_CAPTURE;
                  armed <= 1'b0;
               end
            end
            ST_CAPTURE: begin
               if (!sample_run) begin
                  state <= ST_IDLE;
               end else if (tick) begin
                  smp_cnt <= smp_cnt_inc;
                  if (wr.fifo_almost_full) begin
                     overflow <= 1'b1;
                  end else begin
                     wr.sample_valid <= 1'b1;
                     wr.sample_data  <= sync2;
                  end
                  if (last_sample) begin
                     state        <= ST_DONE;
                     capture_done <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (!sample_run) begin
                  state        <= ST_IDLE;
                  capture_done <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_la_trigger_capture.sv
// Testbench for la_trigger_capture. Each capture scenario is predicted from
// the behavioural rules: trigger cycle T, sample k taken at T + k*2^min(cfg,10)
// from the probe word driven two cycles earlier, strobe one cycle later,
// dropped while almost-full, done with the last due sample.
module tb_la_trigger_capture;
   import la_pkg::*;

   localparam int W  = 6;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  din;
   logic          sample_run;
   logic [CW-1:0] sample_num;
   logic [3:0]    sample_clk_cfg;
   logic [1:0]    trigger_edge;
   logic [2:0]    trigger_channel;
   logic          armed, capture_done, overflow;

   int cyc = 0;
   int tests_run = 0;
   int tests_failed = 0;
   logic [W-1:0] din_log [int];

   la_trigger_capture_if #(.INPUT_WIDTH(W)) wr_if ();

   la_trigger_capture #(.INPUT_WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk             (clk),
      .rst             (rst),
      .din             (din),
      .sample_run      (sample_run),
      .sample_num      (sample_num),
      .sample_clk_cfg  (sample_clk_cfg),
      .trigger_edge    (trigger_edge),
      .trigger_channel (trigger_channel),
      .wr              (wr_if),
      .armed           (armed),
      .capture_done    (capture_done),
      .overflow        (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_all_zero(input string name);
      logic [W+3:0] got;
      got = {wr_if.sample_data, wr_if.sample_valid, armed, capture_done, overflow};
      tests_run++;
      if (got !== '0) begin
         tests_failed++;
         $display("FAIL %s outputs {data,valid,armed,done,ovf} got %h expected 0", name, got);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      din = '0;
      sample_run = 1'b0;
      sample_num = '0;
      sample_clk_cfg = '0;
      trigger_edge = '0;
      trigger_channel = '0;
      wr_if.fifo_almost_full = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("post_reset_idle");
   endtask

   task automatic run_capture(input string name, input int cfg, input int edge_sel,
                              input int ch, input int num, input bit fixed_din,
                              input logic [W-1:0] din_val, input int af_lo,
                              input int af_hi, input int abort_k);
      int s, d, t0, p, a, end_c, done_cyc, exp_done, tk, n;
      bit imm, ovf_exp, armed_seen;
      logic [W-1:0] pre, d_now;
      int exp_cyc[$], got_cyc[$];
      logic [W-1:0] exp_dat[$], got_dat[$];

      imm = (edge_sel == 0) || (ch >= W);
      p   = 1 << ((cfg > MAX_RATE_CFG) ? MAX_RATE_CFG : cfg);
      pre = fixed_din ? din_val : W'($urandom);
      if (!imm) begin
         if (edge_sel == 1) pre[ch] = 1'b0;
         if (edge_sel == 2) pre[ch] = 1'b1;
      end
      s  = cyc + 4;
      d  = s + 3;
      t0 = imm ? s + 2 : d + 3;
      a  = t0 + abort_k * p;
      if (num == 0)          end_c = s + 6;
      else if (abort_k >= 0) end_c = a + 4;
      else                   end_c = t0 + (num - 1) * p + 6;

      sample_num      = CW'(num);
      sample_clk_cfg  = 4'(cfg);
      trigger_edge    = 2'(edge_sel);
      trigger_channel = 3'(ch);
      done_cyc   = -1;
      armed_seen = 1'b0;

      while (cyc < end_c) begin
         if (wr_if.sample_valid) begin
            got_cyc.push_back(cyc);
            got_dat.push_back(wr_if.sample_data);
         end
         if (capture_done && done_cyc < 0) done_cyc = cyc;
         if (cyc == s + 1) armed_seen = armed;

         if (cyc < s || (!imm && cyc < d)) d_now = pre;
         else if (!imm && cyc == d)        d_now = pre ^ (W'(1) << ch);
         else                              d_now = fixed_din ? din_val : W'($urandom);
         din = d_now;
         din_log[cyc] = d_now;
         wr_if.fifo_almost_full = (cyc >= t0 + af_lo) && (cyc <= t0 + af_hi);
         sample_run = (cyc >= s) && !(abort_k >= 0 && cyc >= a);
         if (cyc > s) begin
            sample_num      = $urandom;
            sample_clk_cfg  = 4'($urandom);
            trigger_edge    = 2'($urandom);
            trigger_channel = 3'($urandom);
         end
         @(posedge clk);
         #1;
      end

      ovf_exp = 1'b0;
      for (int k = 0; k < num; k++) begin
         tk = t0 + k * p;
         if (abort_k >= 0 && tk >= a) break;
         if (tk >= t0 + af_lo && tk <= t0 + af_hi) ovf_exp = 1'b1;
         else begin
            exp_cyc.push_back(tk + 1);
            exp_dat.push_back(din_log[tk - 2]);
         end
      end
      if (num == 0)          exp_done = s + 1;
      else if (abort_k >= 0) exp_done = -1;
      else                   exp_done = t0 + (num - 1) * p + 1;

      tests_run++;
      if (got_cyc.size() != exp_cyc.size()) begin
         tests_failed++;
         $display("FAIL %s pulse_count got %0d expected %0d", name, got_cyc.size(), exp_cyc.size());
      end
      n = (got_cyc.size() < exp_cyc.size()) ? got_cyc.size() : exp_cyc.size();
      for (int k = 0; k < n; k++) begin
         tests_run++;
         if (got_cyc[k] != exp_cyc[k]) begin
            tests_failed++;
            $display("FAIL %s pulse%0d_cycle got %0d expected %0d", name, k, got_cyc[k], exp_cyc[k]);
         end
         tests_run++;
         if (got_dat[k] !== exp_dat[k]) begin
            tests_failed++;
            $display("FAIL %s pulse%0d_data got %h expected %h", name, k, got_dat[k], exp_dat[k]);
         end
      end
      tests_run++;
      if (done_cyc != exp_done) begin
         tests_failed++;
         $display("FAIL %s done_cycle got %0d expected %0d", name, done_cyc, exp_done);
      end
      tests_run++;
      if (overflow !== ovf_exp) begin
         tests_failed++;
         $display("FAIL %s overflow got %b expected %b", name, overflow, ovf_exp);
      end
      tests_run++;
      if (armed_seen !== (num > 0)) begin
         tests_failed++;
         $display("FAIL %s armed_after_start got %b expected %b", name, armed_seen, (num > 0));
      end

      sample_run = 1'b0;
      wr_if.fifo_almost_full = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({armed, capture_done, wr_if.sample_valid} !== 3'b000) begin
         tests_failed++;
         $display("FAIL %s idle_after_run_low got %b expected 000", name,
                  {armed, capture_done, wr_if.sample_valid});
      end
   endtask

   task automatic test_edge_trigger();
      run_capture("edge_rise", 0, 1, 2, 4, 1'b0, '0, 1, 0, -1);
      run_capture("edge_fall", 1, 2, 4, 3, 1'b0, '0, 1, 0, -1);
      run_capture("edge_any",  2, 3, 5, 4, 1'b0, '0, 1, 0, -1);
   endtask

   task automatic test_immediate_div8();
      run_capture("imm_div8", 3, 0, 0, 3, 1'b1, 6'h2A, 1, 0, -1);
   endtask

   task automatic test_clamp();
      run_capture("clamp_cfg15", 15, 0, 0, 2, 1'b0, '0, 1, 0, -1);
   endtask

   task automatic test_overflow();
      run_capture("overflow", 0, 0, 0, 8, 1'b0, '0, 2, 3, -1);
   endtask

   task automatic test_abort();
      run_capture("abort", $urandom_range(0, 2), 2, 7, 100, 1'b0, '0, 1, 0, 10);
   endtask

   task automatic test_num_zero();
      run_capture("num_zero", 2, 1, 1, 0, 1'b0, '0, 1, 0, -1);
   endtask

   task automatic test_random();
      int cfg, es, ch, num, lo, hi, ab;
      for (int i = 0; i < 8; i++) begin
         cfg = $urandom_range(0, 3);
         es  = $urandom_range(0, 3);
         ch  = $urandom_range(0, 7);
         num = $urandom_range(1, 6);
         lo  = 1;
         hi  = 0;
         if ($urandom_range(0, 1) == 1) begin
            lo = $urandom_range(0, 6);
            hi = lo + $urandom_range(0, 4);
         end
         ab = -1;
         if (num > 1 && $urandom_range(0, 2) == 0) ab = $urandom_range(1, num - 1);
         run_capture($sformatf("random%0d", i), cfg, es, ch, num, 1'b0, '0, lo, hi, ab);
      end
   endtask

   task automatic test_reset_mid();
      int armed_hits, valid_hits, done_hits;
      sample_num      = CW'(50);
      sample_clk_cfg  = 4'd1;
      trigger_edge    = 2'd0;
      trigger_channel = 3'd0;
      sample_run = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_all_zero("reset_mid_capture");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      armed_hits = 0;
      valid_hits = 0;
      done_hits  = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (armed) armed_hits++;
         if (wr_if.sample_valid) valid_hits++;
         if (capture_done) done_hits++;
      end
      tests_run++;
      if (armed_hits + valid_hits + done_hits != 0) begin
         tests_failed++;
         $display("FAIL reset_hold_run armed/valid/done cycles got %0d/%0d/%0d expected 0/0/0",
                  armed_hits, valid_hits, done_hits);
      end
      sample_run = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sample_clk_cfg = 4'd0;
      trigger_edge   = 2'd1;
      trigger_channel = 3'd3;
      sample_run = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if (armed !== 1'b1) begin
         tests_failed++;
         $display("FAIL fresh_start_after_reset armed got %b expected 1", armed);
      end
      sample_run = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_edge_trigger();
      test_immediate_div8();
      test_clamp();
      test_overflow();
      test_abort();
      test_num_zero();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
